// File: rtl/jk_sync_down_counter.sv
// jk_sync_down_counter: synchronous down counter built from a chain of JK
// flip-flop cells sharing one clock. Each stage toggles when every lower
// stage is 0 (borrow chain). Adds synchronous parallel load (priority over
// en), zero decode and a registered one-cycle borrow pulse on wrap.
//
// Build option: define JK_DOWN_SATURATE_EN to make the counter stop at 0
// instead of wrapping; borrow is then held at 0.

module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

module jk_sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow
);

  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] low_zero;  // low_zero[i]: q[i-1:0] are all 0
  logic             count;
  logic             step;

  assign zero  = ~|q;
  assign count = en & ~load;

`ifdef JK_DOWN_SATURATE_EN
  // At 0 the count is suppressed so every stage sees J=K=0 and holds.
  assign step = count & ~zero;
`else
  assign step = count;
`endif

  // Borrow chain: stage 0 always toggles when counting; higher stages toggle
  // only when all stages below are 0.
  assign low_zero[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign low_zero[i] = low_zero[i-1] & ~q[i-1];
  end

  // Load drives J/K to force din; otherwise J=K=toggle enable.
  for (genvar i = 0; i < WIDTH; i++) begin : g_jk
    assign j[i] = load ?  din[i] : (step & low_zero[i]);
    assign k[i] = load ? ~din[i] : (step & low_zero[i]);
  end

  jk_cell u_cell [WIDTH-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .j     (j),
    .k     (k),
    .q     (q)
  );

  // Borrow pulse: set for one cycle after an enabled count edge at q==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) borrow <= 1'b0;
    else begin
`ifdef JK_DOWN_SATURATE_EN
      borrow <= 1'b0;
`else
      borrow <= count & zero;
`endif
    end
  end

endmodule

// File: tb/tb_jk_sync_down_counter.sv
// Directed bench for jk_sync_down_counter (WIDTH=4). Wrap/sweep steps run in
// the default build; saturation steps run when JK_DOWN_SATURATE_EN is defined.

module tb_jk_sync_down_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] q;
  logic         zero;
  logic         borrow;

  int total = 0;
  int bad   = 0;

  jk_sync_down_counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .load   (load),
    .din    (din),
    .q      (q),
    .zero   (zero),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int eq, input int ez, input int eb);
    chk({tag, ".q"}, int'(q), eq);
    chk({tag, ".zero"}, int'(zero), ez);
    chk({tag, ".borrow"}, int'(borrow), eb);
  endtask

  initial begin
    int pulses;
    int exp_q;
    // Reset state before any edge
    #2;
    chk_all("reset0", 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-clock with q=9
    load = 1'b1; din = 4'd9;
    tick();
    load = 1'b0;
    chk_all("load9", 9, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Count down from a load of 5
    load = 1'b1; din = 4'd5;
    tick();
    load = 1'b0;
    chk_all("ld5", 5, 0, 0);
    en = 1'b1;
    for (int n = 4; n >= 0; n--) begin
      tick();
      chk_all($sformatf("cnt%0d", n), n, (n == 0) ? 1 : 0, 0);
    end

`ifndef JK_DOWN_SATURATE_EN
    // Wrap 0 -> 15 with a single borrow pulse
    tick();
    chk_all("wrap15", 15, 0, 1);
    tick();
    chk_all("wrap14", 14, 0, 0);
`endif

    // Simultaneous load and en: load wins; then hold
    load = 1'b1; en = 1'b1; din = 4'd12;
    tick();
    chk_all("prio12", 12, 0, 0);
    load = 1'b0; en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk_all($sformatf("hold%0d", n), 12, 0, 0);
    end

    // Load at q==0 with en high: no borrow on a load edge
    load = 1'b1; din = 4'd0;
    tick();
    chk_all("ld0", 0, 1, 0);
    en = 1'b1; din = 4'd7;
    tick();
    chk_all("ld7_at0", 7, 0, 0);

`ifndef JK_DOWN_SATURATE_EN
    // Load 0 then en: wrap and borrow
    din = 4'd0;
    tick();
    load = 1'b0;
    chk_all("ld0b", 0, 1, 0);
    tick();
    chk_all("ld0_wrap", 15, 0, 1);

    // Pending borrow dropped by async reset
    load = 1'b1; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    chk_all("pre_rst_wrap", 15, 0, 1);
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all("rst_drop", 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full sweep: 32 edges from 0, 15..0 twice, 2 borrow pulses
    en = 1'b1;
    pulses = 0;
    exp_q = 0;
    for (int n = 0; n < 32; n++) begin
      tick();
      chk($sformatf("sweep_b%0d", n), int'(borrow), (exp_q == 0) ? 1 : 0);
      exp_q = (exp_q + 15) % 16;
      chk($sformatf("sweep_q%0d", n), int'(q), exp_q);
      if (borrow) pulses++;
    end
    chk("sweep_pulses", pulses, 2);
    en = 1'b0;
`else
    // Saturation: from 1, four enabled edges stay at 0, no borrow
    load = 1'b1; en = 1'b0; din = 4'd1;
    tick();
    load = 1'b0;
    chk_all("sat_ld1", 1, 0, 0);
    en = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk_all($sformatf("sat%0d", n), 0, 1, 0);
    end
    load = 1'b1; din = 4'd3;
    tick();
    load = 1'b0; en = 1'b0;
    chk_all("sat_ld3", 3, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
